baud_div: RTL and testbench

- Baud-rate tick generator used by the UART transmitter; instantiated in `uart_tx` as the `baudgen` instance.
- While enabled, it divides the system clock by BAUD and emits a one-clock-wide pulse once per bit period.
- The pulse drives the transmit shift register and the bit counter.
- While disabled, it stays idle and phase-reset, so every transmission starts with a full bit period.

---
 rtl/baud_div.sv | 59 +++++
 tb/tb_baud_div.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_div.sv
// baud_div: baud-rate tick generator for the UART transmitter.
// While clk_en is high it divides clk_in by BAUD and emits a single-cycle
// registered pulse once per bit period. While clk_en is low the counter is
// held at zero, so every enabled run begins with a full bit period.
module baud_div #(
    parameter int BAUD = 104
) (
    input  logic clk_in,
    input  logic rstn,
    input  logic clk_en,
    output logic pulse_out
);

    // Counter just wide enough to hold BAUD-1; at least one bit so BAUD=1 still elaborates.
    localparam int CNT_W = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject divisors outside 1 .. 2^24-1 at elaboration time.
    generate
        if (BAUD < 1 || BAUD > 32'h00FF_FFFF) begin : g_bad_baud
            $error("baud_div: BAUD must be in the range 1 to 2^24-1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;

    // Next-state: wrap at BAUD-1 with a tick, otherwise count; disabled discards the partial count.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!clk_en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State register with synchronous active-low reset taking priority over enable.
    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Tick comes straight from a flop: no combinational path from clk_en.
    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_baud_div.sv
// tb_baud_div: directed tests for baud_div with BAUD = 104, 4, 1 and 8.
// Each instance has its own reset/enable so scenarios run independently.
// After every rising edge the bench waits 1 time unit, then drives new
// inputs and samples outputs; "step k" is the k-th edge of a scenario.
`timescale 1ns/1ps
module tb_baud_div;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst104, en104, p104;
    logic rst4,   en4,   p4;
    logic rst1,   en1,   p1;
    logic rst8,   en8,   p8;

    int checks = 0;
    int errors = 0;

    baud_div #(.BAUD(104)) dut104 (.clk_in(clk), .rstn(rst104), .clk_en(en104), .pulse_out(p104));
    baud_div #(.BAUD(4))   dut4   (.clk_in(clk), .rstn(rst4),   .clk_en(en4),   .pulse_out(p4));
    baud_div #(.BAUD(1))   dut1   (.clk_in(clk), .rstn(rst1),   .clk_en(en1),   .pulse_out(p1));
    baud_div #(.BAUD(8))   dut8   (.clk_in(clk), .rstn(rst8),   .clk_en(en8),   .pulse_out(p8));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held 3 edges with enable high: every output stays low.
    task automatic test_reset();
        rst104 = 1'b0; rst4 = 1'b0; rst1 = 1'b0; rst8 = 1'b0;
        en104 = 1'b1;  en4 = 1'b1;  en1 = 1'b1;  en8 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({p104, p4, p1, p8} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold step %0d: pulses=%b expected=0000", k, {p104, p4, p1, p8});
            end else
                $display("reset_hold step %0d ok", k);
        end
        en104 = 1'b0; en4 = 1'b0; en1 = 1'b0; en8 = 1'b0;
        rst104 = 1'b1; rst4 = 1'b1; rst1 = 1'b1; rst8 = 1'b1;
        step();
        checks++;
        if ({p104, p4, p1, p8} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_idle: pulses=%b expected=0000", {p104, p4, p1, p8});
        end else
            $display("reset_release_idle ok");
    endtask

    // BAUD=104 enabled for 500 edges: ticks at steps 104, 208, 312, 416, each one cycle wide.
    task automatic test_baud104();
        int npulse;
        logic exp;
        npulse = 0;
        en104 = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            step();
            exp = ((k % 104) == 0);
            if (p104 === 1'b1) npulse++;
            checks++;
            if (p104 !== exp) begin
                errors++;
                $display("FAIL baud104 step %0d: pulse=%b expected=%b", k, p104, exp);
            end else if (exp)
                $display("baud104 tick at step %0d ok", k);
        end
        checks++;
        if (npulse !== 4) begin
            errors++;
            $display("FAIL baud104_count: pulses=%0d expected=4", npulse);
        end else
            $display("baud104_count 4 ok");
        en104 = 1'b0;
        step();
        checks++;
        if (p104 !== 1'b0) begin
            errors++;
            $display("FAIL baud104_disable: pulse=%b expected=0", p104);
        end else
            $display("baud104_disable ok");
    endtask

    // BAUD=4: 6 enabled, 2 disabled, then re-enabled; first tick after re-enable is 4 edges later.
    task automatic test_reenable();
        logic exp;
        en4 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (k == 4);
            checks++;
            if (p4 !== exp) begin
                errors++;
                $display("FAIL reenable_run1 step %0d: pulse=%b expected=%b", k, p4, exp);
            end else
                $display("reenable_run1 step %0d pulse=%b ok", k, p4);
        end
        en4 = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++;
            if (p4 !== 1'b0) begin
                errors++;
                $display("FAIL reenable_idle step %0d: pulse=%b expected=0", k, p4);
            end else
                $display("reenable_idle step %0d ok", k);
        end
        en4 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp = (k == 4);
            checks++;
            if (p4 !== exp) begin
                errors++;
                $display("FAIL reenable_run2 step %0d: pulse=%b expected=%b", k, p4, exp);
            end else
                $display("reenable_run2 step %0d pulse=%b ok", k, p4);
        end
        en4 = 1'b0;
        step();
    endtask

    // BAUD=4: enable drops exactly on the terminal-count edge; no tick, count restarts from 0.
    task automatic test_terminal_drop();
        logic exp;
        en4 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (p4 !== 1'b0) begin
                errors++;
                $display("FAIL tdrop_count step %0d: pulse=%b expected=0", k, p4);
            end else
                $display("tdrop_count step %0d ok", k);
        end
        en4 = 1'b0;
        step();
        checks++;
        if (p4 !== 1'b0) begin
            errors++;
            $display("FAIL tdrop_edge: pulse=%b expected=0", p4);
        end else
            $display("tdrop_edge no tick ok");
        en4 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp = (k == 4);
            checks++;
            if (p4 !== exp) begin
                errors++;
                $display("FAIL tdrop_restart step %0d: pulse=%b expected=%b", k, p4, exp);
            end else
                $display("tdrop_restart step %0d pulse=%b ok", k, p4);
        end
        en4 = 1'b0;
        step();
    endtask

    // BAUD=1: high every cycle from the first enabled edge, low one cycle after disable.
    task automatic test_baud1();
        en1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (p1 !== 1'b1) begin
                errors++;
                $display("FAIL baud1_run step %0d: pulse=%b expected=1", k, p1);
            end else
                $display("baud1_run step %0d ok", k);
        end
        en1 = 1'b0;
        step();
        checks++;
        if (p1 !== 1'b0) begin
            errors++;
            $display("FAIL baud1_disable: pulse=%b expected=0", p1);
        end else
            $display("baud1_disable ok");
        en1 = 1'b1;
        step();
        checks++;
        if (p1 !== 1'b1) begin
            errors++;
            $display("FAIL baud1_reenable: pulse=%b expected=1", p1);
        end else
            $display("baud1_reenable ok");
        en1 = 1'b0;
        step();
    endtask

    // BAUD=8: reset pulsed at cnt=5 with enable high; next tick 8 edges after release.
    task automatic test_midrun_reset();
        logic exp;
        en8 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (p8 !== 1'b0) begin
                errors++;
                $display("FAIL midrst_pre step %0d: pulse=%b expected=0", k, p8);
            end else
                $display("midrst_pre step %0d ok", k);
        end
        rst8 = 1'b0;
        step();
        checks++;
        if (p8 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_edge: pulse=%b expected=0", p8);
        end else
            $display("midrst_edge ok");
        rst8 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp = (k == 8);
            checks++;
            if (p8 !== exp) begin
                errors++;
                $display("FAIL midrst_post step %0d: pulse=%b expected=%b", k, p8, exp);
            end else
                $display("midrst_post step %0d pulse=%b ok", k, p8);
        end
        en8 = 1'b0;
        step();
    endtask

    initial begin
        rst104 = 1'b0; rst4 = 1'b0; rst1 = 1'b0; rst8 = 1'b0;
        en104 = 1'b0;  en4 = 1'b0;  en1 = 1'b0;  en8 = 1'b0;
        test_reset();
        test_baud104();
        test_reenable();
        test_terminal_drop();
        test_baud1();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
